// File: rtl/scan_pkg.sv
// scan_pkg: shared FSM encoding, mode constants and output polarity helper for scan_decoder
package scan_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_st_e;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
  function automatic logic inactive_level(input int active_low);
    return active_low != 0;
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: dwell counter with live divider compare, synchronous clear and expire flag
module scan_prescaler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 expire
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  // compared with >= so a lowered div ends the dwell at once and the count never wraps
  assign expire = cnt_q >= div;
  always_comb cnt_d = clr ? '0 : run ? (expire ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot line decoder with direct-load and timed-scan modes
module scan_decoder
  import scan_pkg::*;
#(
  parameter int INPUT_WIDTH  = 4,
  parameter int CHANNELS     = 16,
  parameter int DIV_WIDTH    = 16,
  parameter int BLANK_CYCLES = 2,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic [INPUT_WIDTH-1:0]    d,
  input  logic                      d_valid,
  input  logic [DIV_WIDTH-1:0]      div,
  output logic [2**INPUT_WIDTH-1:0] q,
  output logic [INPUT_WIDTH-1:0]    idx,
  output logic                      step,
  output logic                      frame,
  output logic                      err
);
  localparam int LINES = 2**INPUT_WIDTH;
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [INPUT_WIDTH:0] CH = (INPUT_WIDTH+1)'(CHANNELS);
  localparam logic [INPUT_WIDTH-1:0] LAST = INPUT_WIDTH'(CHANNELS - 1);
  localparam logic [BW-1:0] BLAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic LVL = inactive_level(ACTIVE_LOW);

  scan_st_e st_q, st_d;
  logic [INPUT_WIDTH-1:0] cur_q, cur_d, idx_q, idx_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [LINES-1:0] q_q, q_d;
  logic last_mode_q, last_mode_d;
  logic adv_q, adv_d, wrap_q, wrap_d;
  logic step_q, step_d, frame_q, frame_d, err_q, err_d;
  logic load, bad, adv, run, clr, expire;

  scan_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_pre (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .clr    (clr),
    .div    (div),
    .expire (expire)
  );

  assign load = en && d_valid && ({1'b0, d} < CH);
  assign bad  = en && d_valid && ({1'b0, d} >= CH);

  // priority: disable, then index load, then mode change / wake-up, then scan timing
  always_comb begin
    st_d        = st_q;
    cur_d       = cur_q;
    blank_d     = blank_q;
    last_mode_d = mode;
    adv         = 1'b0;
    run         = 1'b0;
    clr         = 1'b0;
    if (!en) begin
      st_d    = ST_IDLE;
      blank_d = '0;
      clr     = 1'b1;
    end else if (load) begin
      cur_d   = d;
      st_d    = ST_SHOW;
      blank_d = '0;
      clr     = 1'b1;
    end else if (mode != last_mode_q || st_q == ST_IDLE) begin
      st_d    = ST_SHOW;
      blank_d = '0;
      clr     = 1'b1;
    end else if (mode == MODE_DIRECT) begin
      st_d = ST_SHOW;
    end else if (st_q == ST_SHOW) begin
      run = 1'b1;
      if (expire && BLANK_CYCLES == 0) adv = 1'b1;
      else if (expire) st_d = ST_BLANK;
    end else if (blank_q >= BLAST) begin
      blank_d = '0;
      st_d    = ST_SHOW;
      adv     = 1'b1;
    end else begin
      blank_d = blank_q + 1'b1;
    end
    if (adv) cur_d = (cur_q == LAST) ? '0 : cur_q + 1'b1;
    adv_d  = adv;
    wrap_d = adv && (cur_q == LAST);
  end

  // outputs trail the state by one edge so q, idx, step and frame stay aligned
  always_comb begin
    q_d     = {LINES{LVL}} ^ ((en && st_q == ST_SHOW) ? (LINES'(1) << cur_q) : '0);
    idx_d   = cur_q;
    step_d  = adv_q;
    frame_d = wrap_q;
    err_d   = bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q        <= ST_IDLE;
      cur_q       <= '0;
      blank_q     <= '0;
      last_mode_q <= MODE_DIRECT;
      adv_q       <= 1'b0;
      wrap_q      <= 1'b0;
      q_q         <= {LINES{LVL}};
      idx_q       <= '0;
      step_q      <= 1'b0;
      frame_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      cur_q       <= cur_d;
      blank_q     <= blank_d;
      last_mode_q <= last_mode_d;
      adv_q       <= adv_d;
      wrap_q      <= wrap_d;
      q_q         <= q_d;
      idx_q       <= idx_d;
      step_q      <= step_d;
      frame_q     <= frame_d;
      err_q       <= err_d;
    end
  end

  assign q     = q_q;
  assign idx   = idx_q;
  assign step  = step_q;
  assign frame = frame_q;
  assign err   = err_q;
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: three decoder configurations driven in lockstep and checked against a cycle model
module tb_scan_decoder;
  logic clk = 1'b0;
  logic rst_n, en, mode, d_valid;
  logic [3:0] d;
  logic [7:0] div;
  logic [15:0] q0, q1, q2;
  logic [3:0] idx0, idx1, idx2;
  logic step0, step1, step2, frame0, frame1, frame2, err0, err1, err2;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scan_decoder #(.INPUT_WIDTH(4), .CHANNELS(10), .DIV_WIDTH(8), .BLANK_CYCLES(2), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .d_valid(d_valid), .div(div),
    .q(q0), .idx(idx0), .step(step0), .frame(frame0), .err(err0));
  scan_decoder #(.INPUT_WIDTH(4), .CHANNELS(16), .DIV_WIDTH(8), .BLANK_CYCLES(0), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .d_valid(d_valid), .div(div),
    .q(q1), .idx(idx1), .step(step1), .frame(frame1), .err(err1));
  scan_decoder #(.INPUT_WIDTH(4), .CHANNELS(4), .DIV_WIDTH(8), .BLANK_CYCLES(2), .ACTIVE_LOW(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .d_valid(d_valid), .div(div),
    .q(q2), .idx(idx2), .step(step2), .frame(frame2), .err(err2));

  // ph: 0 idle, 1 showing a line, 2 blanking; t: cycles spent in the current phase
  typedef struct {
    int ph, sel, t, lastm;
    bit adv, wrap;
    logic [15:0] q;
    int idx;
    bit step, frame, err;
  } mdl_t;
  mdl_t m0, m1, m2;

  function automatic mdl_t mnext(mdl_t m, int ch, int bc, int al);
    mdl_t n = m;
    if (!rst_n) begin
      n.ph = 0; n.sel = 0; n.t = 0; n.lastm = 0; n.adv = 0; n.wrap = 0;
      n.q = (al != 0) ? 16'hFFFF : 16'h0000;
      n.idx = 0; n.step = 0; n.frame = 0; n.err = 0;
      return n;
    end
    n.q = (en && m.ph == 1) ? (16'(1) << m.sel) : 16'h0000;
    if (al != 0) n.q = ~n.q;
    n.idx = m.sel;
    n.step = m.adv;
    n.frame = m.wrap;
    n.err = en && d_valid && int'(d) >= ch;
    n.adv = 0;
    n.wrap = 0;
    n.lastm = int'(mode);
    if (!en) begin
      n.ph = 0; n.t = 0;
    end else if (d_valid && int'(d) < ch) begin
      n.sel = int'(d); n.ph = 1; n.t = 0;
    end else if (int'(mode) != m.lastm || m.ph == 0) begin
      n.ph = 1; n.t = 0;
    end else if (!mode) begin
      n.ph = 1;
    end else if ((m.ph == 1 && m.t >= int'(div) && bc == 0) || (m.ph == 2 && m.t + 1 >= bc)) begin
      n.ph = 1; n.t = 0; n.adv = 1; n.wrap = (m.sel == ch - 1); n.sel = (m.sel + 1) % ch;
    end else if (m.ph == 1 && m.t >= int'(div)) begin
      n.ph = 2; n.t = 0;
    end else begin
      n.t = m.t + 1;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string k, input mdl_t m, input logic [15:0] q, input logic [3:0] ix,
                           input logic st, input logic fr, input logic er);
    check({k, "_q"}, 32'(q), 32'(m.q));
    check({k, "_idx"}, 32'(ix), 32'(m.idx));
    check({k, "_step"}, 32'(st), 32'(m.step));
    check({k, "_frame"}, 32'(fr), 32'(m.frame));
    check({k, "_err"}, 32'(er), 32'(m.err));
  endtask

  task automatic cyc();
    @(posedge clk);
    m0 = mnext(m0, 10, 2, 0);
    m1 = mnext(m1, 16, 0, 1);
    m2 = mnext(m2, 4, 2, 0);
    @(negedge clk);
    check_dut("d0", m0, q0, idx0, step0, frame0, err0);
    check_dut("d1", m1, q1, idx1, step1, frame1, err1);
    check_dut("d2", m2, q2, idx2, step2, frame2, err2);
  endtask

  task automatic measure(input string tag, input int e0, input int e1, input int e2);
    int fa[3] = '{-1, -1, -1};
    int fb[3] = '{-1, -1, -1};
    int ex[3] = '{e0, e1, e2};
    logic [2:0] fr;
    for (int i = 0; i < 200; i++) begin
      cyc();
      fr = {frame2, frame1, frame0};
      for (int k = 0; k < 3; k++)
        if (fr[k]) begin
          if (fa[k] < 0) fa[k] = i;
          else if (fb[k] < 0) fb[k] = i;
        end
    end
    for (int k = 0; k < 3; k++) check($sformatf("%s%0d", tag, k), 32'(fb[k] - fa[k]), 32'(ex[k]));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; d_valid = 1'b0; d = '0; div = 8'd3;
    repeat (2) cyc();
    check("rst_q0", 32'(q0), 32'h0000);
    check("rst_q1", 32'(q1), 32'hFFFF);
    rst_n = 1'b1; en = 1'b1; d = 4'd5; d_valid = 1'b1;
    cyc();
    d_valid = 1'b0;
    cyc();
    check("load_q0", 32'(q0), 32'h0020);
    check("load_idx0", 32'(idx0), 32'd5);
    check("load_q1", 32'(q1), 32'hFFDF);
    d = 4'd12; d_valid = 1'b1;
    cyc();
    d_valid = 1'b0;
    check("bad_err", 32'(err0), 32'd1);
    check("bad_idx", 32'(idx0), 32'd5);
    cyc();
    check("bad_err_once", 32'(err0), 32'd0);
    check("bad_q", 32'(q0), 32'h0020);
    d = 4'd9; d_valid = 1'b1;
    cyc();
    d_valid = 1'b0;
    cyc();
    check("top_line_q0", 32'(q0), 32'h0200);
    mode = 1'b1;
    measure("period_div3_", 60, 64, 24);
    div = 8'd0;
    measure("period_div0_", 30, 16, 12);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("step_cont", 32'(step1), 32'd1);
    end
    div = 8'd3;
    repeat (7) cyc();
    en = 1'b0;
    cyc();
    check("dis_q0", 32'(q0), 32'h0000);
    check("dis_q1", 32'(q1), 32'hFFFF);
    en = 1'b1;
    repeat (9) cyc();
    rst_n = 1'b0;
    cyc();
    check("midrst_idx0", 32'(idx0), 32'd0);
    check("midrst_q1", 32'(q1), 32'hFFFF);
    rst_n = 1'b1; div = 8'd100; d = 4'd1; d_valid = 1'b1;
    cyc();
    d_valid = 1'b0;
    repeat (50) cyc();
    check("slow_q0", 32'(q0), 32'h0002);
    div = 8'd2;
    cyc();
    cyc();
    check("div_drop_q0", 32'(q0), 32'h0000);
    for (int i = 0; i < 1500; i++) begin
      rst_n = $urandom_range(99) != 0;
      en = $urandom_range(19) != 0;
      if ($urandom_range(29) == 0) mode = ~mode;
      d_valid = $urandom_range(9) == 0;
      d = 4'($urandom_range(15));
      if ($urandom_range(39) == 0) div = 8'($urandom_range(6));
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
